serial_loader: RTL and testbench

Serial boot loader that sits upstream of the 6502 SoC. It holds the CPU in reset and receives a binary image over the serial RX pin. Each data byte is written into system memory through a byte-wide write port. Once it has validated a checksummed frame, or the boot window has expired with no frame started, it releases the CPU reset. It shares the RX pin with the ACIA; the ACIA only sees traffic after the CPU runs.

---
 rtl/serial_loader_pkg.sv | 29 ++
 rtl/serial_loader_uart_rx.sv | 130 +++++++++++++
 rtl/serial_loader.sv | 186 ++++++++++++++++++
 tb/tb_serial_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial boot loader: frame FSM encoding,
// receiver FSM encoding, the sync byte and the baud divider derivation.
package serial_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    ADDR_H    = 3'd1,
    ADDR_L    = 3'd2,
    LEN_H     = 3'd3,
    LEN_L     = 3'd4,
    DATA      = 3'd5,
    CHK       = 3'd6,
    RUN       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC = 8'h55;

  function automatic int calc_div(input int freq, input int rate);
    return freq / rate;
  endfunction

endpackage

// File: rtl/serial_loader_uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte strobe and a one-cycle framing-error pulse when the stop bit is low.
module uart_rx_8n1
  import serial_loader_pkg::*;
#(
  parameter int clk_freq = 35000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int DIV   = calc_div(clk_freq, baud);
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic             rx_fall_s;
  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             valid_r, valid_s;
  logic             ferr_r, ferr_s;

  assign rx_fall_s    = rx_prev_r & ~rx_sync_r;
  assign rx_data      = shift_r;
  assign rx_valid     = valid_r;
  assign rx_frame_err = ferr_r;

  // Synchronizer; flops reset to the idle level so reset release is no edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state, bit timing and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r <= RX_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      valid_r    <= 1'b0;
      ferr_r     <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      valid_r    <= valid_s;
      ferr_r     <= ferr_s;
    end
  end

  // Next-state: start re-check at DIV/2, then one sample per DIV cycles
  always_comb begin
    rx_state_s = rx_state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    valid_s    = 1'b0;
    ferr_s     = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) begin
          rx_state_s = RX_START;
          cnt_s      = CNT_ZERO;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s     = CNT_ZERO;
          bit_idx_s = 3'd0;
          if (!rx_sync_r) begin
            rx_state_s = RX_BITS;
          end else begin
            rx_state_s = RX_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RX_BITS: begin
        if (cnt_r == CNT_FULL) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_r == CNT_FULL) begin
          cnt_s      = CNT_ZERO;
          valid_s    = rx_sync_r;
          ferr_s     = ~rx_sync_r;
          rx_state_s = RX_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        cnt_s      = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/serial_loader.sv
// Serial boot loader: holds the CPU in reset, writes a checksummed frame into
// memory, then releases the CPU (or releases it after an idle boot window).
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int clk_freq  = 35000000,
  parameter int baud      = 115200,
  parameter int boot_wait = 35000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        error
);

  localparam int TMR_W = $clog2(boot_wait + 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(boot_wait);

  logic [7:0]       rx_data_s;
  logic             rx_valid_s, rx_ferr_s;
  state_t           state_r, state_s;
  logic [15:0]      ptr_r, ptr_s;
  logic [15:0]      len_r, len_s;
  logic [7:0]       sum_r, sum_s, sum_add_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic             we_s, err_set_s, busy_s;
  logic [15:0]      mem_addr_r;
  logic [7:0]       mem_data_r;
  logic             mem_we_r, cpu_reset_n_r, busy_r, error_r;

  uart_rx_8n1 #(
    .clk_freq(clk_freq),
    .baud    (baud)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_data     (rx_data_s),
    .rx_valid    (rx_valid_s),
    .rx_frame_err(rx_ferr_s)
  );

  assign sum_add_s   = sum_r + rx_data_s;
  assign busy_s      = (state_r != WAIT_SYNC) && (state_r != RUN);
  assign mem_addr    = mem_addr_r;
  assign mem_data    = mem_data_r;
  assign mem_we      = mem_we_r;
  assign cpu_reset_n = cpu_reset_n_r;
  assign busy        = busy_r;
  assign error       = error_r;

  // Frame state, pointer, length, checksum and idle timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= WAIT_SYNC;
      ptr_r   <= 16'h0000;
      len_r   <= 16'h0000;
      sum_r   <= 8'h00;
      timer_r <= TMR_ZERO;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      len_r   <= len_s;
      sum_r   <= sum_s;
      timer_r <= timer_s;
    end
  end

  // Registered outputs; the write port holds its last address/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_r    <= 16'h0000;
      mem_data_r    <= 8'h00;
      mem_we_r      <= 1'b0;
      cpu_reset_n_r <= 1'b0;
      busy_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      mem_we_r      <= we_s;
      cpu_reset_n_r <= (state_s == RUN);
      busy_r        <= busy_s;
      error_r       <= error_r | err_set_s;
      if (we_s) begin
        mem_addr_r <= ptr_r;
        mem_data_r <= rx_data_s;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_data_r <= mem_data_r;
      end
    end
  end

  // Frame FSM; a byte strobe takes priority over a coincident timer expiry
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    len_s     = len_r;
    sum_s     = sum_r;
    we_s      = 1'b0;
    err_set_s = rx_ferr_s & (state_r != RUN);
    if (state_r == RUN) begin
      timer_s = timer_r;
    end else begin
      timer_s = timer_r + TMR_ONE;
    end

    if (state_r == RUN) begin
      state_s = RUN;
    end else if (rx_valid_s) begin
      timer_s = TMR_ZERO;
      case (state_r)
        WAIT_SYNC: begin
          if (rx_data_s == SYNC) begin
            state_s = ADDR_H;
          end else begin
            state_s = WAIT_SYNC;
          end
        end
        ADDR_H: begin
          ptr_s   = {rx_data_s, ptr_r[7:0]};
          sum_s   = rx_data_s;
          state_s = ADDR_L;
        end
        ADDR_L: begin
          ptr_s   = {ptr_r[15:8], rx_data_s};
          sum_s   = sum_add_s;
          state_s = LEN_H;
        end
        LEN_H: begin
          len_s   = {rx_data_s, len_r[7:0]};
          sum_s   = sum_add_s;
          state_s = LEN_L;
        end
        LEN_L: begin
          len_s = {len_r[15:8], rx_data_s};
          sum_s = sum_add_s;
          if ({len_r[15:8], rx_data_s} == 16'h0000) begin
            state_s = CHK;
          end else begin
            state_s = DATA;
          end
        end
        DATA: begin
          we_s  = 1'b1;
          sum_s = sum_add_s;
          ptr_s = ptr_r + 16'h0001;
          len_s = len_r - 16'h0001;
          if (len_r == 16'h0001) begin
            state_s = CHK;
          end else begin
            state_s = DATA;
          end
        end
        CHK: begin
          if (sum_add_s == 8'h00) begin
            state_s = RUN;
          end else begin
            err_set_s = 1'b1;
            state_s   = WAIT_SYNC;
          end
        end
        default: begin
          state_s = WAIT_SYNC;
        end
      endcase
    end else if (timer_r == TMR_END) begin
      timer_s = TMR_ZERO;
      if (state_r == WAIT_SYNC) begin
        state_s = RUN;
      end else begin
        err_set_s = 1'b1;
        state_s   = WAIT_SYNC;
      end
    end else begin
      state_s = state_r;
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: frames are serialized on rx, expected
// memory writes are queued as bytes are sent and compared as writes appear.
module tb_serial_loader;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD      = 100000;
  localparam int BOOT_WAIT = 2000;
  localparam int DIV       = CLK_FREQ / BAUD;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx      = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, cpu_reset_n, busy, error;

  int          checks  = 0;
  int          errors  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_mem[0:63];
  int          obs_cnt = 0;
  int          rd_ptr  = 0;
  logic [7:0]  dq[$];

  always #5 clk = ~clk;

  serial_loader #(
    .clk_freq (CLK_FREQ),
    .baud     (BAUD),
    .boot_wait(BOOT_WAIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .error      (error)
  );

  // Capture every cycle with the write strobe high
  always @(negedge clk) begin
    if (mem_we === 1'b1 && obs_cnt < 64) begin
      obs_mem[obs_cnt[5:0]] <= {mem_addr, mem_data};
      obs_cnt <= obs_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_addr"},    32'(mem_addr),    32'h0000);
    check({tag, " mem_data"},    32'(mem_data),    32'h00);
    check({tag, " mem_we"},      32'(mem_we),      32'd0);
    check({tag, " cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " error"},       32'(error),       32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard: pop one expected write per observed write
  task automatic drain(input string tag);
    while (rd_ptr < obs_cnt) begin
      if (exp_q.size() == 0) begin
        check({tag, " unexpected write"}, {8'h00, obs_mem[rd_ptr[5:0]]}, 32'hFFFF_FFFF);
      end else begin
        check({tag, " write"}, {8'h00, obs_mem[rd_ptr[5:0]]}, {8'h00, exp_q.pop_front()});
      end
      rd_ptr++;
    end
    check({tag, " missing writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sends sync, header and payload from dq; returns the checksum byte
  task automatic send_body(input logic [15:0] addr, output logic [7:0] chk);
    logic [7:0]  sum;
    logic [15:0] ptr;
    logic [15:0] len;
    len = 16'(dq.size());
    sum = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
    ptr = addr;
    send_byte(8'h55, 1'b1);
    send_byte(addr[15:8], 1'b1);
    send_byte(addr[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    send_byte(len[7:0], 1'b1);
    foreach (dq[i]) begin
      exp_q.push_back({ptr, dq[i]});
      ptr = ptr + 16'd1;
      sum = sum + dq[i];
      send_byte(dq[i], 1'b1);
    end
    chk = 8'h00 - sum;
  endtask

  task automatic wait_cpu_release(output int n);
    n = 0;
    while (cpu_reset_n !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [7:0] chk;
    int         n;

    // Valid frame
    apply_reset("s1 reset");
    dq.delete();
    dq.push_back(8'hA9); dq.push_back(8'h01); dq.push_back(8'h60);
    send_body(16'h0200, chk);
    check("s1 busy mid-frame", 32'(busy), 32'd1);
    check("s1 cpu held before chk", 32'(cpu_reset_n), 32'd0);
    send_byte(chk, 1'b1);
    repeat (2) @(negedge clk);
    check("s1 cpu released", 32'(cpu_reset_n), 32'd1);
    check("s1 error", 32'(error), 32'd0);
    check("s1 busy idle", 32'(busy), 32'd0);
    drain("s1");

    // Bad checksum, then a good frame
    apply_reset("s2 reset");
    send_body(16'h0200, chk);
    send_byte(chk ^ 8'h05, 1'b1);
    repeat (2) @(negedge clk);
    check("s2 error set", 32'(error), 32'd1);
    check("s2 cpu held", 32'(cpu_reset_n), 32'd0);
    check("s2 busy idle", 32'(busy), 32'd0);
    drain("s2 bad");
    send_body(16'h0200, chk);
    send_byte(chk, 1'b1);
    repeat (2) @(negedge clk);
    check("s2 cpu released", 32'(cpu_reset_n), 32'd1);
    check("s2 error sticky", 32'(error), 32'd1);
    drain("s2 good");

    // Boot timeout with idle rx
    apply_reset("s3 reset");
    wait_cpu_release(n);
    check("s3 boot delay", 32'(n >= 1999 && n <= 2003), 32'd1);
    check("s3 error", 32'(error), 32'd0);
    drain("s3");

    // Junk bytes then an address-wrapping frame
    apply_reset("s4 reset");
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    check("s4 junk ignored", 32'(busy), 32'd0);
    dq.delete();
    dq.push_back(8'h11); dq.push_back(8'h22);
    send_body(16'hFFFF, chk);
    send_byte(chk, 1'b1);
    repeat (2) @(negedge clk);
    check("s4 cpu released", 32'(cpu_reset_n), 32'd1);
    check("s4 error", 32'(error), 32'd0);
    drain("s4");

    // Framing error on a would-be sync byte
    apply_reset("s5 reset");
    send_byte(8'h55, 1'b0);
    repeat (DIV) @(negedge clk);
    check("s5 framing error", 32'(error), 32'd1);
    check("s5 byte discarded", 32'(busy), 32'd0);
    check("s5 cpu held", 32'(cpu_reset_n), 32'd0);
    drain("s5 ferr");

    // Short glitch must not produce a byte (would restart the boot timer)
    apply_reset("s5 glitch reset");
    repeat (1000) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("s5 glitch error", 32'(error), 32'd0);
    check("s5 glitch busy", 32'(busy), 32'd0);
    wait_cpu_release(n);
    check("s5 glitch boot delay", 32'((n + 1023) >= 1999 && (n + 1023) <= 2003), 32'd1);
    drain("s5 glitch");

    // Mid-frame timeout, then reset during a data phase
    apply_reset("s6 reset");
    send_byte(8'h55, 1'b1);
    send_byte(8'h10, 1'b1);
    check("s6 busy", 32'(busy), 32'd1);
    repeat (2010) @(negedge clk);
    check("s6 timeout error", 32'(error), 32'd1);
    check("s6 back to sync", 32'(busy), 32'd0);
    check("s6 cpu held", 32'(cpu_reset_n), 32'd0);
    dq.delete();
    dq.push_back(8'hAA); dq.push_back(8'hBB);
    exp_q.push_back({16'h0010, 8'hAA});
    exp_q.push_back({16'h0011, 8'hBB});
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("s6 busy in data", 32'(busy), 32'd1);
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("s6 abort");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("s6 idle after abort", 32'(busy), 32'd0);
    drain("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
